// File: rtl/addsub_seq_32_pkg.sv
// Shared types and constants for the byte-serial add/subtract unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state encoding, op encoding, index-width helper.
package addsub_seq_32_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operation select encoding on the op input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Byte index counter width: clog2 of the slice count, never below 1 bit.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/addsub_seq_32_if.sv
// Request/response bundle for the byte-serial add/subtract unit.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the unit is not busy.
//
// Signals:
//   start     - request a new operation (sampled on rising clk)
//   op        - 0 = a+b, 1 = a-b
//   a, b      - operands, 8*NBYTES bits
//   busy      - operation in progress
//   done      - one-cycle completion pulse
//   result    - sum or difference
//   c_out     - add: carry out of MSB; sub: borrow (a < b unsigned)
//   over_flow - signed overflow of the full-width result
interface addsub_seq_32_if #(
  parameter int NBYTES = 4
);
  logic                  start;
  logic                  op;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [8*NBYTES-1:0]   result;
  logic                  c_out;
  logic                  over_flow;

  // Requester side.
  modport master (
    output start, op, a, b,
    input  busy, done, result, c_out, over_flow
  );

  // Arithmetic unit side.
  modport slave (
    input  start, op, a, b,
    output busy, done, result, c_out, over_flow
  );
endinterface

// File: rtl/addsub_seq_32_full_adder_8_bit_gate.sv
// 8-bit gate-level ripple add/subtract slice (a + (b ^ sel) + c_in).
// Latency: combinational, 0 cycles.
// Backpressure: none.
//
// Ports:
//   a, b      - 8-bit operand bytes
//   sel       - 0 = add, 1 = subtract (inverts b)
//   c_in      - raw carry into bit 0
//   sum       - 8-bit result byte
//   c_out     - carry out of bit 7, reported as a borrow when sel = 1
//   over_flow - signed overflow of this byte (carry into MSB xor carry out)
module full_adder_8_bit_gate (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sel,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       c_out,
  output logic       over_flow
);

  logic [8:0] c;
  logic [7:0] bx;

  assign c[0] = c_in;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign bx[i]    = b[i] ^ sel;
    assign sum[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  // For subtraction the raw carry is the complement of the borrow.
  assign c_out     = c[8] ^ sel;
  assign over_flow = c[8] ^ c[7];

endmodule

// File: rtl/addsub_seq_32.sv
// Byte-serial add/subtract: one shared 8-bit slice processes NBYTES bytes LSB first.
// Latency: NBYTES cycles from the accepting edge to the done pulse.
// Backpressure: start ignored while busy; a start during the done cycle is taken back-to-back.
//
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - addsub_seq_32_if slave modport (start/op/a/b in; busy/done/result/c_out/over_flow out)
module addsub_seq_32
  import addsub_seq_32_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  addsub_seq_32_if.slave        bus
);

  localparam int                W        = 8 * NBYTES;
  localparam int                IW       = idx_width(NBYTES);
  localparam logic [IW-1:0]     LAST_IDX = IW'(NBYTES - 1);

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            op_q;
  logic [W-1:0]    result_q;
  logic            c_out_q;
  logic            over_flow_q;
  logic            busy_q;
  logic            done_q;

  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic            s_sel;
  logic            s_c_in;
  logic [7:0]      s_sum;
  logic            s_c_out;
  logic            s_over_flow;

  // Select the current operand bytes from the latched operands.
  always_comb begin
    a_byte = 8'h00;
    b_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == i[IW-1:0]) begin
        a_byte = a_q[i*8 +: 8];
        b_byte = b_q[i*8 +: 8];
      end
    end
  end

  assign s_sel  = (op_q == OP_SUB);
  // Byte 0 gets op as carry-in, which completes the two's-complement negate of b.
  assign s_c_in = (idx_q == '0) ? op_q : carry_q;

  full_adder_8_bit_gate u_slice (
    .a         (a_byte),
    .b         (b_byte),
    .sel       (s_sel),
    .c_in      (s_c_in),
    .sum       (s_sum),
    .c_out     (s_c_out),
    .over_flow (s_over_flow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      result_q    <= '0;
      c_out_q     <= 1'b0;
      over_flow_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            idx_q   <= '0;
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end

        ST_RUN: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == i[IW-1:0]) begin
              result_q[i*8 +: 8] <= s_sum;
            end
          end
          // Store the raw carry; the slice reports a borrow for subtraction.
          carry_q <= s_c_out ^ op_q;
          if (idx_q == LAST_IDX) begin
            c_out_q     <= s_c_out;
            over_flow_q <= s_over_flow;
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.c_out     = c_out_q;
  assign bus.over_flow = over_flow_q;

endmodule

// File: tb/tb_addsub_seq_32.sv
// Scoreboard bench for addsub_seq_32: directed vectors push expectations, a monitor checks each done.
// Latency checked: done must appear exactly 4 cycles after the accepting edge.
// Backpressure exercised: start held through RUN, back-to-back accept in the done cycle, reset abort.
module tb_addsub_seq_32;
  import addsub_seq_32_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        co;
    logic        ov;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  addsub_seq_32_if #(.NBYTES(4)) bus ();

  addsub_seq_32 #(.NBYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no operation (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result",    bus.result,           e.res);
        chk("c_out",     {31'd0, bus.c_out},     {31'd0, e.co});
        chk("over_flow", {31'd0, bus.over_flow}, {31'd0, e.ov});
        chk("done_cycle", cyc,                 e.done_cyc);
        chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [31:0] res, input logic co, input logic ov, input int dc);
    exp_t e;
    e.res = res; e.co = co; e.ov = ov; e.done_cyc = dc;
    sb.push_back(e);
  endtask

  // Wait (bounded) until the monitor has consumed every expectation.
  task automatic drain(input string name);
    for (int i = 0; i < 30 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Called 1 time unit after a rising edge. Operands are scrambled after acceptance.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] res, input logic co, input logic ov, input string name);
    bus.op = o; bus.a = x; bus.b = y; bus.start = 1'b1;
    push_exp(res, co, ov, cyc + 5);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = ~x; bus.b = ~y; bus.op = ~o;
    chk({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
    drain(name);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = OP_ADD; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   {31'd0, bus.busy},      32'd0);
    chk("rst_done",   {31'd0, bus.done},      32'd0);
    chk("rst_result", bus.result,             32'd0);
    chk("rst_c_out",  {31'd0, bus.c_out},     32'd0);
    chk("rst_ovf",    {31'd0, bus.over_flow}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(OP_ADD, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, "add_ff_1");
    run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
    run_op(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, "add_carry");
    run_op(OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, "sub_borrow");

    // Start held high through RUN: only the first is taken, the second in the done cycle.
    c = cyc;
    bus.op = OP_ADD; bus.a = 32'h1111_1111; bus.b = 32'h2222_2222; bus.start = 1'b1;
    push_exp(32'h3333_3333, 1'b0, 1'b0, c + 5);
    push_exp(32'h1122_3344, 1'b0, 1'b0, c + 10);
    @(posedge clk); #1;
    bus.a = 32'h0102_0304; bus.b = 32'h1020_3040;
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
    drain("b2b");

    run_op(OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, "sub_ovf");

    // Reset while the byte index is 2: everything clears at once, no done afterwards.
    bus.op = OP_ADD; bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy",   {31'd0, bus.busy},      32'd0);
    chk("abort_done",   {31'd0, bus.done},      32'd0);
    chk("abort_result", bus.result,             32'd0);
    chk("abort_c_out",  {31'd0, bus.c_out},     32'd0);
    chk("abort_ovf",    {31'd0, bus.over_flow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {31'd0, bus.done}, 32'd0);
    end

    run_op(OP_ADD, 32'd5, 32'd3, 32'h0000_0008, 1'b0, 1'b0, "add_5_3");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_seq_32.md
ADDSUB_SEQ_32 -- requirements
Module: addsub_seq_32

Interface
REQ-001 SHALL have parameter NBYTES, default 4: number of 8-bit slices processed per operation; operand width is 8*NBYTES.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled on a rising edge of clk.
REQ-005 SHALL have port op  input  1  operation select: 0 = a+b, 1 = a-b.
REQ-006 SHALL have port a  input  8*NBYTES  first operand.
REQ-007 SHALL have port b  input  8*NBYTES  second operand.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port result  output  8*NBYTES  sum or difference.
REQ-011 SHALL have port c_out  output  1  add: carry out of MSB; sub: borrow (1 when a < b unsigned).
REQ-012 SHALL have port over_flow  output  1  signed two's-complement overflow of the full-width result.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL accept start only in IDLE or DONE: latch a, b, op; clear byte index to 0; go to RUN.
REQ-015 SHALL ignore start while in RUN, with no effect on latched operands, index or outputs.
REQ-016 SHALL, in RUN, each cycle present latched byte [index] of a and b plus op as sel to one shared 8-bit add/sub slice.
REQ-017 SHALL write the slice sum into result byte [index] on the same edge, then increment index.
REQ-018 SHALL drive slice c_in = op at index 0.
REQ-019 SHALL drive slice c_in for index k>0 from a carry register holding (slice c_out XOR op) of byte k-1, i.e. the raw carry.
REQ-020 SHALL, when the index NBYTES-1 byte is written, capture slice c_out into c_out and slice over_flow into over_flow, and go to DONE.
REQ-021 SHALL have a latency of exactly NBYTES cycles: done high in the cycle following the NBYTES-th RUN edge after the accepting edge.
REQ-022 SHALL hold busy = 1 exactly while state is RUN.
REQ-023 SHALL hold done = 1 exactly while state is DONE (one cycle).
REQ-024 SHALL go from DONE to IDLE when start = 0, or back to RUN when start = 1 (back-to-back, no idle cycle).
REQ-025 SHALL hold result, c_out and over_flow stable from done until the next completing operation.
REQ-026 SHALL leave result bytes not yet written in a new operation holding prior values; only the value at done is defined.
REQ-027 SHALL ignore changes on a, b, op after acceptance.

Reset
REQ-028 SHALL, on rst = 1 (asynchronous, regardless of state), force state IDLE, index 0, carry register 0, busy 0, done 0, result 0, c_out 0, over_flow 0.
REQ-029 SHALL abort an operation on reset mid-RUN, with no done pulse; the first start after rst deasserts is accepted normally.

Structure
REQ-030 SHALL place state encoding (IDLE/RUN/DONE) and the op encoding constants in a shared package.
REQ-031 SHALL instantiate exactly one full_adder_8_bit_gate as the shared slice; no other arithmetic on operand data.
REQ-032 SHALL size the index counter as clog2(NBYTES), minimum 1 bit.

Verification
REQ-033 SHALL cover add 0x000000FF + 0x00000001 -> result 0x00000100, c_out 0, over_flow 0, done exactly 4 cycles after accepting edge.
REQ-034 SHALL cover add 0x7FFFFFFF + 0x00000001 -> 0x80000000, over_flow 1, c_out 0; and add 0xFFFFFFFF + 0x00000001 -> 0x00000000, c_out 1, over_flow 0.
REQ-035 SHALL cover sub 0x00000000 - 0x00000001 -> 0xFFFFFFFF, c_out 1, over_flow 0; and sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, over_flow 1, c_out 0.
REQ-036 SHALL cover start held high through RUN with different operands -> only first accepted; done once after 4 cycles; second accepted in the DONE cycle; its done follows 4 cycles later.
REQ-037 SHALL cover rst asserted during RUN index 2 -> busy/done/result/c_out/over_flow 0 immediately, no done pulse; a subsequent add 5 + 3 yields 0x00000008.
